serial_tx_queue: RTL and testbench

Parametrised result transmitter for the miner's host link. It accepts result words (nonces) on a single-cycle `send` strobe into a small FIFO and serialises each word MSB-byte-first through the `uart_transmitter`. Results that arrive while a previous word is still on the line are therefore queued instead of lost. It sits between the hashing core's golden-nonce output and the UART TX pin, replacing the single-word, busy-gated transmitter.

---
 rtl/serial_tx_queue.sv | 194 +++++++++++++++++++
 tb/tb_serial_tx_queue.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_queue.sv
// serial_tx_queue: queues result words in a small FIFO and sends each one
// MSB byte first through uart_transmitter, so results that arrive while the
// line is busy wait in the queue instead of being lost.
// Optional build macro: SERIAL_TX_DROP_COUNT_EN builds the 16-bit saturating
// drop counter; without it drop_count is tied to zero.

// Plain 8N1 transmitter. It has no reset. Its counters use >= compares, so any
// power-up state drains to idle within one frame.
module uart_transmitter #(
  parameter int comm_clk_frequency = 109_000_000,
  parameter int baud_rate          = 115_200
) (
  input  logic       clk,
  output logic       uart_tx,
  input  logic       rx_new_byte,
  input  logic [7:0] rx_byte,
  output logic       tx_ready
);
  localparam int DIV = (comm_clk_frequency / baud_rate < 1) ? 1 : comm_clk_frequency / baud_rate;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic          r_busy;
  logic [CW-1:0] r_baud;
  logic [3:0]    r_bits;
  logic [9:0]    r_shift;

  // Load a frame {stop, data, start} on a new byte, then shift it out LSB first.
  always_ff @(posedge clk) begin
    if (!r_busy) begin
      if (rx_new_byte) begin
        r_busy  <= 1'b1;
        r_baud  <= '0;
        r_bits  <= '0;
        r_shift <= {1'b1, rx_byte, 1'b0};
      end
    end else if (r_baud >= CW'(DIV - 1)) begin
      r_baud  <= '0;
      r_shift <= {1'b1, r_shift[9:1]};
      if (r_bits >= 4'd9) r_busy <= 1'b0;
      else                r_bits <= r_bits + 4'd1;
    end else begin
      r_baud <= r_baud + 1'b1;
    end
  end

  assign uart_tx  = r_busy ? r_shift[0] : 1'b1;
  assign tx_ready = ~r_busy;
endmodule

module serial_tx_queue #(
  parameter int comm_clk_frequency = 109_000_000,
  parameter int WORD_BYTES         = 4,
  parameter int FIFO_DEPTH         = 4,
  parameter int BYTE_GAP           = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [8*WORD_BYTES-1:0]       word,
  input  logic                          send,
  output logic                          full,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  output logic                          TxD
);
  localparam int WW  = 8 * WORD_BYTES;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;
  localparam int BCW = $clog2(WORD_BYTES + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SEND  = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;
  localparam logic [1:0] S_WAITR = 2'd3;

  logic [WW-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]  r_level;
  logic [LW-1:0]  w_level_next;
  logic           r_full;
  logic           r_overflow;
  logic [1:0]     r_state;
  logic [WW-1:0]  r_shift;
  logic [BCW-1:0] r_bytes_left;
  logic [3:0]     r_gap;
  logic           r_rx_new_byte;
  logic [7:0]     r_rx_byte;
  logic           w_tx_ready;
  logic           w_push, w_pop;

  // full is registered, so a pop in the same cycle cannot rescue a push.
  assign w_push = send & ~r_full;
  assign w_pop  = (r_state == S_IDLE) && (r_level != '0);

  // Occupancy after this edge; level is the authoritative count.
  always_comb begin
    w_level_next = r_level;
    if (w_push && !w_pop)      w_level_next = r_level + 1'b1;
    else if (!w_push && w_pop) w_level_next = r_level - 1'b1;
  end

  // Queue storage; written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= word;
  end

  // Pointers, occupancy, full flag and sticky overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_next;
      r_full  <= (w_level_next == LW'(FIFO_DEPTH));
      if (send && r_full) r_overflow <= 1'b1;
    end
  end

`ifdef SERIAL_TX_DROP_COUNT_EN
  logic [15:0] r_drop_count;

  // Saturating count of pushes dropped because the queue was full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                    r_drop_count <= '0;
    else if (send && r_full && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
  end

  assign drop_count = r_drop_count;
`else
  assign drop_count = 16'h0000;
`endif

  // Transmit FSM: pop one whole word, then hand bytes to the UART one at a
  // time with a gap after each start pulse so tx_ready has time to drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_shift       <= '0;
      r_bytes_left  <= '0;
      r_gap         <= '0;
      r_rx_new_byte <= 1'b0;
      r_rx_byte     <= '0;
    end else begin
      r_rx_new_byte <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_shift      <= r_mem[r_rd_ptr];
            r_bytes_left <= BCW'(WORD_BYTES);
            r_state      <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_tx_ready) begin
            r_rx_new_byte <= 1'b1;
            r_rx_byte     <= r_shift[WW-1 -: 8];
            r_shift       <= r_shift << 8;
            r_bytes_left  <= r_bytes_left - 1'b1;
            r_gap         <= 4'(BYTE_GAP);
            r_state       <= S_GAP;
          end
        end
        S_GAP: begin
          r_gap <= r_gap - 4'd1;
          if (r_gap <= 4'd1) r_state <= S_WAITR;
        end
        default: begin
          if (w_tx_ready) r_state <= (r_bytes_left != '0) ? S_SEND : S_IDLE;
        end
      endcase
    end
  end

  uart_transmitter #(
    .comm_clk_frequency(comm_clk_frequency)
  ) u_uart (
    .clk         (clk),
    .uart_tx     (TxD),
    .rx_new_byte (r_rx_new_byte),
    .rx_byte     (r_rx_byte),
    .tx_ready    (w_tx_ready)
  );

  assign full     = r_full;
  assign level    = r_level;
  assign overflow = r_overflow;
  assign busy     = (r_level != '0) || (r_state != S_IDLE);
endmodule

// File: tb/tb_serial_tx_queue.sv
// Bench for serial_tx_queue: three instances (4-byte/depth-4, 1-byte/depth-2,
// 8-byte/depth-2). A UART decoder per TxD line rebuilds the byte stream, which
// is compared with the byte sequence expected from the words the bench
// pushed and the queue capacity rules.
`timescale 1ns/1ps
module tb_serial_tx_queue;
  localparam int CLK_HZ = 460_800;   // 4 clocks per bit at 115200 baud
  localparam int FRAME  = 40;
  localparam int GAP    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [31:0] word0 = '0;
  logic        send0 = 1'b0, full0, busy0, ovf0;
  logic [2:0]  level0;
  logic [15:0] drop0;
  logic [7:0]  word1 = '0;
  logic        send1 = 1'b0, full1, busy1, ovf1;
  logic [1:0]  level1;
  logic [15:0] drop1;
  logic [63:0] word2 = '0;
  logic        send2 = 1'b0, full2, busy2, ovf2;
  logic [1:0]  level2;
  logic [15:0] drop2;
  logic [2:0]  txd_w;

  int n_pass = 0, n_total = 0, cyc = 0;
  int pulses0 = 0, consec_err = 0;
  logic prev0 = 1'b0, prev1 = 1'b0, prev2 = 1'b0;
  logic [7:0]  exp_q[$];
  logic [31:0] stim0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_tx_queue #(.comm_clk_frequency(CLK_HZ), .WORD_BYTES(4), .FIFO_DEPTH(4), .BYTE_GAP(GAP)) dut0 (
    .clk(clk), .reset_n(rst_n), .word(word0), .send(send0), .full(full0), .busy(busy0),
    .level(level0), .overflow(ovf0), .drop_count(drop0), .TxD(txd_w[0]));
  serial_tx_queue #(.comm_clk_frequency(CLK_HZ), .WORD_BYTES(1), .FIFO_DEPTH(2), .BYTE_GAP(GAP)) dut1 (
    .clk(clk), .reset_n(rst_n), .word(word1), .send(send1), .full(full1), .busy(busy1),
    .level(level1), .overflow(ovf1), .drop_count(drop1), .TxD(txd_w[1]));
  serial_tx_queue #(.comm_clk_frequency(CLK_HZ), .WORD_BYTES(8), .FIFO_DEPTH(2), .BYTE_GAP(GAP)) dut2 (
    .clk(clk), .reset_n(rst_n), .word(word2), .send(send2), .full(full2), .busy(busy2),
    .level(level2), .overflow(ovf2), .drop_count(drop2), .TxD(txd_w[2]));

  // UART line decoders: record each byte and the cycle its start bit was seen.
  for (genvar gi = 0; gi < 3; gi++) begin : g_dec
    logic [7:0] q[$];
    int ts[$];
    int stop_t = 0;
    logic [7:0] b;
    int t0;
    always begin
      @(negedge clk);
      if (txd_w[gi] === 1'b0) begin
        t0 = cyc;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          b[i] = txd_w[gi];
        end
        repeat (4) @(negedge clk);
        q.push_back(b);
        ts.push_back(t0);
        stop_t = cyc;
      end
    end
  end

  // Byte-start pulse monitor: counts pulses and back-to-back highs.
  always @(negedge clk) begin
    if (dut0.r_rx_new_byte) pulses0++;
    if ((dut0.r_rx_new_byte && prev0) || (dut1.r_rx_new_byte && prev1) ||
        (dut2.r_rx_new_byte && prev2)) consec_err++;
    prev0 = dut0.r_rx_new_byte;
    prev1 = dut1.r_rx_new_byte;
    prev2 = dut2.r_rx_new_byte;
  end

  function automatic void push_word(input logic [63:0] w, input int nb);
    for (int k = nb - 1; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; send0 = 1'b0; send1 = 1'b0; send2 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drive_burst0();
    foreach (stim0[i]) begin
      word0 = stim0[i]; send0 = 1'b1;
      @(negedge clk);
    end
    send0 = 1'b0;
  endtask

  task automatic wait_idle0(input int budget, output bit ok);
    int n = 0;
    while (busy0 !== 1'b0 && n < budget) begin @(negedge clk); n++; end
    ok = (busy0 === 1'b0);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++; if (full0 !== 1'b0) $display("FAIL reset_full actual=%b required=0", full0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL reset_busy actual=%b required=0", busy0); else n_pass++;
    n_total++; if (level0 !== 3'd0) $display("FAIL reset_level actual=%0d required=0", level0); else n_pass++;
    n_total++; if (ovf0 !== 1'b0) $display("FAIL reset_overflow actual=%b required=0", ovf0); else n_pass++;
    n_total++; if (drop0 !== 16'h0) $display("FAIL reset_drop actual=%h required=0000", drop0); else n_pass++;
    n_total++; if (txd_w[0] !== 1'b1) $display("FAIL reset_txd actual=%b required=1", txd_w[0]); else n_pass++;
    n_total++; if ({busy1, busy2, level1, level2} !== 6'd0)
      $display("FAIL reset_sweep_duts actual=%b required=000000", {busy1, busy2, level1, level2}); else n_pass++;
    $display("reset: checks done");
  endtask

  task automatic test_single();
    int base, nb, p0, fall_cyc, n;
    apply_reset();
    exp_q.delete(); push_word(64'hDEADBEEF, 4);
    base = g_dec[0].q.size(); p0 = pulses0;
    word0 = 32'hDEADBEEF; send0 = 1'b1;
    @(negedge clk); send0 = 1'b0;
    n_total++; if (level0 !== 3'd1) $display("FAIL single_level_after_push actual=%0d required=1", level0); else n_pass++;
    n_total++; if (busy0 !== 1'b1) $display("FAIL single_busy_rise actual=%b required=1", busy0); else n_pass++;
    @(negedge clk);
    n_total++; if (level0 !== 3'd0) $display("FAIL single_level_after_pop actual=%0d required=0", level0); else n_pass++;
    n_total++; if (dut0.r_rx_new_byte !== 1'b0) $display("FAIL single_pulse_early actual=1 required=0"); else n_pass++;
    @(negedge clk);
    n_total++; if (dut0.r_rx_new_byte !== 1'b1) $display("FAIL single_first_pulse actual=0 required=1"); else n_pass++;
    n = 0;
    while (busy0 !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    fall_cyc = cyc;
    n_total++; if (busy0 !== 1'b0) $display("FAIL single_idle_timeout actual=busy required=idle"); else n_pass++;
    n_total++; if (fall_cyc <= g_dec[0].stop_t)
      $display("FAIL single_busy_hold actual_fall=%0d required_after=%0d", fall_cyc, g_dec[0].stop_t); else n_pass++;
    repeat (4) @(negedge clk);
    nb = g_dec[0].q.size() - base;
    n_total++; if (nb !== exp_q.size()) $display("FAIL single_count actual=%0d required=%0d", nb, exp_q.size()); else n_pass++;
    for (int i = 0; i < exp_q.size() && i < nb; i++) begin
      n_total++;
      if (g_dec[0].q[base+i] !== exp_q[i]) $display("FAIL single_byte%0d actual=%h required=%h", i, g_dec[0].q[base+i], exp_q[i]);
      else n_pass++;
    end
    n_total++; if (pulses0 - p0 !== 4) $display("FAIL single_pulses actual=%0d required=4", pulses0 - p0); else n_pass++;
    n_total++; if (level0 !== 3'd0) $display("FAIL single_final_level actual=%0d required=0", level0); else n_pass++;
    $display("single: word DEADBEEF, %0d bytes seen", nb);
  endtask

  task automatic test_burst();
    int base, nb, bad_gap;
    bit ok;
    apply_reset();
    exp_q.delete(); stim0.delete();
    for (int i = 1; i <= 4; i++) begin stim0.push_back(32'(i)); push_word(64'(i), 4); end
    base = g_dec[0].q.size();
    drive_burst0();
    n_total++; if (level0 !== 3'd3) $display("FAIL burst_level actual=%0d required=3", level0); else n_pass++;
    wait_idle0(3000, ok);
    n_total++; if (!ok) $display("FAIL burst_idle_timeout actual=busy required=idle"); else n_pass++;
    nb = g_dec[0].q.size() - base;
    n_total++; if (nb !== 16) $display("FAIL burst_count actual=%0d required=16", nb); else n_pass++;
    for (int i = 0; i < 16 && i < nb; i++) begin
      n_total++;
      if (g_dec[0].q[base+i] !== exp_q[i]) $display("FAIL burst_byte%0d actual=%h required=%h", i, g_dec[0].q[base+i], exp_q[i]);
      else n_pass++;
    end
    bad_gap = 0;
    for (int i = 1; i < nb; i++) begin
      int idle = g_dec[0].ts[base+i] - g_dec[0].ts[base+i-1] - FRAME;
      if (idle > GAP + 2 || idle < GAP + 1) bad_gap++;
    end
    n_total++; if (bad_gap !== 0) $display("FAIL burst_gaps actual=%0d_bad required=0_bad", bad_gap); else n_pass++;
    n_total++; if (ovf0 !== 1'b0) $display("FAIL burst_overflow actual=%b required=0", ovf0); else n_pass++;
    $display("burst: 4 words, %0d bytes seen", nb);
  endtask

  task automatic test_overflow();
    int base, nb;
    bit ok;
    apply_reset();
    exp_q.delete(); stim0.delete();
    for (int i = 0; i < 6; i++) begin
      stim0.push_back(32'hA0B0C000 + 32'(i));
      if (i < 5) push_word(64'(32'hA0B0C000 + 32'(i)), 4);
    end
    base = g_dec[0].q.size();
    drive_burst0();
    n_total++; if (level0 !== 3'd4) $display("FAIL ovf_level actual=%0d required=4", level0); else n_pass++;
    n_total++; if (full0 !== 1'b1) $display("FAIL ovf_full actual=%b required=1", full0); else n_pass++;
    n_total++; if (ovf0 !== 1'b1) $display("FAIL ovf_flag actual=%b required=1", ovf0); else n_pass++;
    wait_idle0(5000, ok);
    n_total++; if (!ok) $display("FAIL ovf_idle_timeout actual=busy required=idle"); else n_pass++;
    nb = g_dec[0].q.size() - base;
    n_total++; if (nb !== 20) $display("FAIL ovf_count actual=%0d required=20", nb); else n_pass++;
    for (int i = 0; i < 20 && i < nb; i++) begin
      n_total++;
      if (g_dec[0].q[base+i] !== exp_q[i]) $display("FAIL ovf_byte%0d actual=%h required=%h", i, g_dec[0].q[base+i], exp_q[i]);
      else n_pass++;
    end
`ifdef SERIAL_TX_DROP_COUNT_EN
    n_total++; if (drop0 !== 16'd1) $display("FAIL ovf_drop actual=%0d required=1", drop0); else n_pass++;
`else
    n_total++; if (drop0 !== 16'd0) $display("FAIL ovf_drop actual=%0d required=0", drop0); else n_pass++;
`endif
    n_total++; if ({ovf0, full0, level0} !== 5'b10000)
      $display("FAIL ovf_after actual=%b required=10000", {ovf0, full0, level0}); else n_pass++;
    $display("overflow: 6 sends, %0d bytes seen", nb);
  endtask

  task automatic test_simul();
    int base, nb;
    bit ok;
    apply_reset();
    exp_q.delete(); push_word(64'h12345678, 4); push_word(64'h9ABCDEF0, 4);
    base = g_dec[0].q.size();
    word0 = 32'h12345678; send0 = 1'b1;
    @(negedge clk);
    n_total++; if (level0 !== 3'd1) $display("FAIL simul_level1 actual=%0d required=1", level0); else n_pass++;
    word0 = 32'h9ABCDEF0;
    @(negedge clk); send0 = 1'b0;
    n_total++; if (level0 !== 3'd1) $display("FAIL simul_level_hold actual=%0d required=1", level0); else n_pass++;
    wait_idle0(2000, ok);
    n_total++; if (!ok) $display("FAIL simul_idle_timeout actual=busy required=idle"); else n_pass++;
    nb = g_dec[0].q.size() - base;
    n_total++; if (nb !== 8) $display("FAIL simul_count actual=%0d required=8", nb); else n_pass++;
    for (int i = 0; i < 8 && i < nb; i++) begin
      n_total++;
      if (g_dec[0].q[base+i] !== exp_q[i]) $display("FAIL simul_byte%0d actual=%h required=%h", i, g_dec[0].q[base+i], exp_q[i]);
      else n_pass++;
    end
    $display("simul: push during pop, %0d bytes seen", nb);
  endtask

  task automatic test_reset_mid();
    int base, nb, p0, p1, n;
    apply_reset();
    base = g_dec[0].q.size(); p0 = pulses0;
    word0 = 32'hCAFEF00D; send0 = 1'b1;
    @(negedge clk); send0 = 1'b0;
    n = 0;
    while (pulses0 - p0 < 2 && n < 500) begin @(negedge clk); n++; end
    n_total++; if (pulses0 - p0 < 2) $display("FAIL rmid_second_byte_timeout actual=%0d required=2", pulses0 - p0); else n_pass++;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    p1 = pulses0;
    @(negedge clk);
    n_total++; if ({level0, busy0, ovf0} !== 5'd0)
      $display("FAIL rmid_state actual=%b required=00000", {level0, busy0, ovf0}); else n_pass++;
    repeat (200) @(negedge clk);
    n_total++; if (pulses0 !== p1) $display("FAIL rmid_pulses actual=%0d required=0", pulses0 - p1); else n_pass++;
    nb = g_dec[0].q.size() - base;
    n_total++; if (nb !== 2) $display("FAIL rmid_count actual=%0d required=2", nb); else n_pass++;
    n_total++; if (nb >= 2 && {g_dec[0].q[base], g_dec[0].q[base+1]} !== 16'hCAFE)
      $display("FAIL rmid_bytes actual=%h%h required=cafe", g_dec[0].q[base], g_dec[0].q[base+1]); else n_pass++;
    $display("reset mid-word: %0d bytes seen", nb);
  endtask

  task automatic test_random();
    int base, nb, k, acc;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      apply_reset();
      exp_q.delete(); stim0.delete();
      k = $urandom_range(1, 7);
      acc = (k < 5) ? k : 5;
      for (int i = 0; i < k; i++) begin
        logic [31:0] w = $urandom;
        stim0.push_back(w);
        if (i < acc) push_word(64'(w), 4);
      end
      base = g_dec[0].q.size();
      drive_burst0();
      wait_idle0(5000, ok);
      n_total++; if (!ok) $display("FAIL rand%0d_idle_timeout actual=busy required=idle", it); else n_pass++;
      nb = g_dec[0].q.size() - base;
      n_total++; if (nb !== exp_q.size()) $display("FAIL rand%0d_count actual=%0d required=%0d", it, nb, exp_q.size()); else n_pass++;
      for (int i = 0; i < exp_q.size() && i < nb; i++) begin
        n_total++;
        if (g_dec[0].q[base+i] !== exp_q[i]) $display("FAIL rand%0d_byte%0d actual=%h required=%h", it, i, g_dec[0].q[base+i], exp_q[i]);
        else n_pass++;
      end
      n_total++; if (ovf0 !== (k > 5)) $display("FAIL rand%0d_overflow actual=%b required=%b", it, ovf0, k > 5); else n_pass++;
`ifdef SERIAL_TX_DROP_COUNT_EN
      n_total++; if (drop0 !== 16'(k - acc)) $display("FAIL rand%0d_drop actual=%0d required=%0d", it, drop0, k - acc); else n_pass++;
`else
      n_total++; if (drop0 !== 16'd0) $display("FAIL rand%0d_drop actual=%0d required=0", it, drop0); else n_pass++;
`endif
      $display("random burst %0d: %0d sends, %0d accepted, %0d bytes seen", it, k, acc, nb);
    end
  endtask

  task automatic test_sweep();
    int base, nb, n, to_err;
    // One byte per word, depth 2: ten words force several pointer wraps.
    apply_reset();
    exp_q.delete(); to_err = 0;
    base = g_dec[1].q.size();
    for (int i = 0; i < 10; i++) begin
      logic [7:0] w = 8'($urandom);
      push_word(64'(w), 1);
      n = 0;
      while (full1 === 1'b1 && n < 2000) begin @(negedge clk); n++; end
      if (full1 !== 1'b0) to_err++;
      word1 = w; send1 = 1'b1;
      @(negedge clk); send1 = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    n = 0;
    while (busy1 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (busy1 !== 1'b0) to_err++;
    repeat (4) @(negedge clk);
    n_total++; if (to_err !== 0) $display("FAIL sweep1_timeouts actual=%0d required=0", to_err); else n_pass++;
    nb = g_dec[1].q.size() - base;
    n_total++; if (nb !== 10) $display("FAIL sweep1_count actual=%0d required=10", nb); else n_pass++;
    for (int i = 0; i < 10 && i < nb; i++) begin
      n_total++;
      if (g_dec[1].q[base+i] !== exp_q[i]) $display("FAIL sweep1_byte%0d actual=%h required=%h", i, g_dec[1].q[base+i], exp_q[i]);
      else n_pass++;
    end
    n_total++; if ({ovf1, level1} !== 3'd0) $display("FAIL sweep1_final actual=%b required=000", {ovf1, level1}); else n_pass++;
    $display("sweep WORD_BYTES=1: 10 words, %0d bytes seen", nb);

    // Eight bytes per word, depth 2.
    apply_reset();
    exp_q.delete(); to_err = 0;
    base = g_dec[2].q.size();
    for (int i = 0; i < 10; i++) begin
      logic [63:0] w = {$urandom, $urandom};
      push_word(w, 8);
      n = 0;
      while (full2 === 1'b1 && n < 2000) begin @(negedge clk); n++; end
      if (full2 !== 1'b0) to_err++;
      word2 = w; send2 = 1'b1;
      @(negedge clk); send2 = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    n = 0;
    while (busy2 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    if (busy2 !== 1'b0) to_err++;
    repeat (4) @(negedge clk);
    n_total++; if (to_err !== 0) $display("FAIL sweep8_timeouts actual=%0d required=0", to_err); else n_pass++;
    nb = g_dec[2].q.size() - base;
    n_total++; if (nb !== 80) $display("FAIL sweep8_count actual=%0d required=80", nb); else n_pass++;
    for (int i = 0; i < 80 && i < nb; i++) begin
      n_total++;
      if (g_dec[2].q[base+i] !== exp_q[i]) $display("FAIL sweep8_byte%0d actual=%h required=%h", i, g_dec[2].q[base+i], exp_q[i]);
      else n_pass++;
    end
    n_total++; if ({ovf2, level2} !== 3'd0) $display("FAIL sweep8_final actual=%b required=000", {ovf2, level2}); else n_pass++;
    $display("sweep WORD_BYTES=8: 10 words, %0d bytes seen", nb);
  endtask

  initial begin
    repeat (60) @(negedge clk);
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simul();
    test_reset_mid();
    test_random();
    test_sweep();
    n_total++; if (consec_err !== 0) $display("FAIL pulse_spacing actual=%0d_back_to_back required=0", consec_err); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
